imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_if.sv | 45 ++++
 rtl/imem_arbiter.sv | 111 +++++++++++
 tb/tb_imem_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_arbiter_if.sv
// Bundle of the fetch, loader and memory-port signals of the instruction
// memory arbiter. The arbiter connects through the slave modport. The master
// modport is the combined view of the fetch requester, the loader requester
// and the memory.
//
// Handshake: a requester raises req with a stable addr (and wdata) and holds
// them until it sees gnt high in the same cycle. The request is consumed at
// the rising edge where req && gnt. Dropping req before gnt withdraws the
// request with no side effect. f_rvalid/f_err and l_err are one-cycle
// responses in the cycle after the grant. There is no ready/backpressure on
// the response side.
interface imem_arbiter_if #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
);
  logic          f_req;
  logic [31:0]   f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [31:0]   f_rdata;
  logic          f_err;
  logic          l_req;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;
  logic          l_gnt;
  logic          l_err;
  logic [AW:0]   load_count;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_addr, l_wdata, m_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_err, load_count,
           m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_addr, l_wdata, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_err, load_count,
           m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter that shares one synchronous instruction-memory port
// between a fetch (read) requester and a loader (write) requester. It checks
// the address, reports bad addresses and counts successful loader writes.
module imem_arbiter #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  imem_arbiter_if.slave bus
);

  typedef enum logic {
    GRANT_LOADER = 1'b0,
    GRANT_FETCH  = 1'b1
  } grant_e;

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
  localparam logic [AW:0] COUNT_MAX  = (AW + 1)'(DEPTH);

  grant_e      last_grant;
  logic        f_legal;
  logic        l_legal;
  logic        fetch_win;
  logic        loader_win;
  logic        f_rvalid_q;
  logic        f_err_q;
  logic        rd_ok_q;
  logic        l_err_q;
  logic [AW:0] load_count_q;

  // Address check: the address must be word aligned and inside the memory.
  always_comb begin
    f_legal = (bus.f_addr[1:0] == 2'b00) && (bus.f_addr < ADDR_LIMIT);
    l_legal = (bus.l_addr[1:0] == 2'b00) && (bus.l_addr < ADDR_LIMIT);
  end

  // Grant selection. On a conflict the requester that was not granted last wins.
  // Nothing is granted while reset is high.
  always_comb begin
    fetch_win  = 1'b0;
    loader_win = 1'b0;
    if (!reset) begin
      if (bus.f_req && bus.l_req) begin
        if (last_grant == GRANT_LOADER) fetch_win  = 1'b1;
        else                            loader_win = 1'b1;
      end else begin
        fetch_win  = bus.f_req;
        loader_win = bus.l_req;
      end
    end
  end

  // Memory port drive. Idle or illegal grants leave the port parked at zero.
  always_comb begin
    bus.m_en    = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    if (fetch_win && f_legal) begin
      bus.m_en   = 1'b1;
      bus.m_addr = bus.f_addr[AW+1:2];
    end else if (loader_win && l_legal) begin
      bus.m_en    = 1'b1;
      bus.m_we    = 1'b1;
      bus.m_addr  = bus.l_addr[AW+1:2];
      bus.m_wdata = bus.l_wdata;
    end
  end

  // Round-robin history. It changes on every grant. After reset it holds
  // "loader", so the first conflict goes to fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           last_grant <= GRANT_LOADER;
    else if (fetch_win)  last_grant <= GRANT_FETCH;
    else if (loader_win) last_grant <= GRANT_LOADER;
  end

  // One-cycle response pulses after each grant. Async reset also cancels a read
  // that is still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_rvalid_q <= 1'b0;
      f_err_q    <= 1'b0;
      rd_ok_q    <= 1'b0;
      l_err_q    <= 1'b0;
    end else begin
      f_rvalid_q <= fetch_win;
      f_err_q    <= fetch_win && !f_legal;
      rd_ok_q    <= fetch_win && f_legal;
      l_err_q    <= loader_win && !l_legal;
    end
  end

  // Count of successful loader writes. It saturates at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                 load_count_q <= '0;
    else if (loader_win && l_legal && load_count_q != COUNT_MAX) load_count_q <= load_count_q + 1'b1;
  end

  // Read data passes the synchronous memory output straight through during a
  // good read response. Otherwise it reads as zero.
  assign bus.f_gnt      = fetch_win;
  assign bus.l_gnt      = loader_win;
  assign bus.f_rvalid   = f_rvalid_q;
  assign bus.f_err      = f_err_q;
  assign bus.f_rdata    = rd_ok_q ? bus.m_rdata : 32'h0;
  assign bus.l_err      = l_err_q;
  assign bus.load_count = load_count_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter. It includes a small synchronous memory
// model on the memory port. Inputs change on the falling edge. Combinational
// outputs are sampled 1 time unit later. Registered outputs are sampled
// 1 time unit after the rising edge.
module tb_imem_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] mem     [0:63];
  logic [31:0] exp_mem [0:63];

  imem_arbiter_if #(.DEPTH(64), .AW(6)) bus ();

  imem_arbiter #(.DEPTH(64), .AW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory model.
  always @(posedge clk) begin
    if (bus.m_en && bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
    if (bus.m_en && !bus.m_we) bus.m_rdata <= mem[bus.m_addr];
  end

  task automatic idle_inputs();
    bus.f_req   = 1'b0;
    bus.f_addr  = 32'h0;
    bus.l_req   = 1'b0;
    bus.l_addr  = 32'h0;
    bus.l_wdata = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.f_req = 1'b1;
    bus.l_req = 1'b1;
    #1;
    checks++; if (bus.f_gnt !== 1'b0) begin errors++; $display("FAIL reset_f_gnt got %b want 0", bus.f_gnt); end
    checks++; if (bus.l_gnt !== 1'b0) begin errors++; $display("FAIL reset_l_gnt got %b want 0", bus.l_gnt); end
    checks++; if (bus.m_en !== 1'b0) begin errors++; $display("FAIL reset_m_en got %b want 0", bus.m_en); end
    checks++; if (bus.f_rvalid !== 1'b0) begin errors++; $display("FAIL reset_f_rvalid got %b want 0", bus.f_rvalid); end
    checks++; if (bus.f_rdata !== 32'h0) begin errors++; $display("FAIL reset_f_rdata got %h want 0", bus.f_rdata); end
    checks++; if (bus.load_count !== 7'd0) begin errors++; $display("FAIL reset_load_count got %0d want 0", bus.load_count); end
    do_reset();
  endtask

  task automatic test_load_then_fetch();
    do_reset();
    bus.l_req = 1'b1; bus.l_addr = 32'h2C; bus.l_wdata = 32'h0094_8663;
    #1;
    checks++; if (bus.l_gnt !== 1'b1 || bus.f_gnt !== 1'b0) begin errors++; $display("FAIL lf_l_gnt got l=%b f=%b want l=1 f=0", bus.l_gnt, bus.f_gnt); end
    checks++; if (bus.m_en !== 1'b1 || bus.m_we !== 1'b1) begin errors++; $display("FAIL lf_write_en got en=%b we=%b want 1 1", bus.m_en, bus.m_we); end
    checks++; if (bus.m_addr !== 6'd11) begin errors++; $display("FAIL lf_write_addr got %0d want 11", bus.m_addr); end
    checks++; if (bus.m_wdata !== 32'h0094_8663) begin errors++; $display("FAIL lf_write_data got %h want 00948663", bus.m_wdata); end
    @(negedge clk);
    bus.l_req = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 32'h2C;
    #1;
    checks++; if (bus.f_gnt !== 1'b1 || bus.m_en !== 1'b1 || bus.m_we !== 1'b0 || bus.m_addr !== 6'd11)
      begin errors++; $display("FAIL lf_read_port got gnt=%b en=%b we=%b addr=%0d want 1 1 0 11", bus.f_gnt, bus.m_en, bus.m_we, bus.m_addr); end
    @(posedge clk); #1;
    checks++; if (bus.f_rvalid !== 1'b1 || bus.f_err !== 1'b0) begin errors++; $display("FAIL lf_rvalid got v=%b e=%b want 1 0", bus.f_rvalid, bus.f_err); end
    checks++; if (bus.f_rdata !== 32'h0094_8663) begin errors++; $display("FAIL lf_rdata got %h want 00948663", bus.f_rdata); end
    checks++; if (bus.load_count !== 7'd1) begin errors++; $display("FAIL lf_load_count got %0d want 1", bus.load_count); end
    @(negedge clk);
    bus.f_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.f_rvalid !== 1'b0) begin errors++; $display("FAIL lf_rvalid_pulse got %b want 0", bus.f_rvalid); end
  endtask

  task automatic test_round_robin();
    logic exp_f;
    do_reset();
    bus.f_req = 1'b1; bus.f_addr = 32'h0;
    bus.l_req = 1'b1; bus.l_addr = 32'h4; bus.l_wdata = 32'h1111_1111;
    for (int i = 0; i < 6; i++) begin
      exp_f = (i % 2 == 0);
      #1;
      checks++; if (bus.f_gnt !== exp_f || bus.l_gnt !== !exp_f)
        begin errors++; $display("FAIL rr_cycle%0d got f=%b l=%b want f=%b l=%b", i, bus.f_gnt, bus.l_gnt, exp_f, !exp_f); end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_illegal();
    do_reset();
    bus.f_req = 1'b1; bus.f_addr = 32'h06;
    #1;
    checks++; if (bus.f_gnt !== 1'b1 || bus.m_en !== 1'b0) begin errors++; $display("FAIL ill_f06_port got gnt=%b en=%b want 1 0", bus.f_gnt, bus.m_en); end
    @(negedge clk);
    bus.f_addr = 32'h100;
    #1;
    checks++; if (bus.f_rvalid !== 1'b1 || bus.f_err !== 1'b1 || bus.f_rdata !== 32'h0)
      begin errors++; $display("FAIL ill_f06_resp got v=%b e=%b d=%h want 1 1 0", bus.f_rvalid, bus.f_err, bus.f_rdata); end
    checks++; if (bus.f_gnt !== 1'b1 || bus.m_en !== 1'b0) begin errors++; $display("FAIL ill_f100_port got gnt=%b en=%b want 1 0", bus.f_gnt, bus.m_en); end
    @(negedge clk);
    idle_inputs();
    bus.l_req = 1'b1; bus.l_addr = 32'h101; bus.l_wdata = 32'hFFFF_FFFF;
    #1;
    checks++; if (bus.f_rvalid !== 1'b1 || bus.f_err !== 1'b1 || bus.f_rdata !== 32'h0)
      begin errors++; $display("FAIL ill_f100_resp got v=%b e=%b d=%h want 1 1 0", bus.f_rvalid, bus.f_err, bus.f_rdata); end
    checks++; if (bus.l_gnt !== 1'b1 || bus.m_en !== 1'b0 || bus.m_we !== 1'b0)
      begin errors++; $display("FAIL ill_l101_port got gnt=%b en=%b we=%b want 1 0 0", bus.l_gnt, bus.m_en, bus.m_we); end
    @(posedge clk); #1;
    checks++; if (bus.l_err !== 1'b1) begin errors++; $display("FAIL ill_l_err got %b want 1", bus.l_err); end
    checks++; if (bus.load_count !== 7'd0) begin errors++; $display("FAIL ill_load_count got %0d want 0", bus.load_count); end
    checks++; if (bus.f_rvalid !== 1'b0) begin errors++; $display("FAIL ill_f_rvalid_after got %b want 0", bus.f_rvalid); end
    @(negedge clk);
    bus.l_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.l_err !== 1'b0) begin errors++; $display("FAIL ill_l_err_pulse got %b want 0", bus.l_err); end
  endtask

  task automatic test_saturate_and_back_to_back();
    logic [6:0] exp_cnt;
    do_reset();
    bus.l_req = 1'b1;
    for (int i = 0; i < 66; i++) begin
      bus.l_addr  = (i < 64) ? 32'(4 * i) : 32'(4 * (i - 64));
      bus.l_wdata = (i < 64) ? (32'hC0DE_0000 | 32'(i)) : (32'hDEAD_BEE0 + 32'(i - 64));
      exp_mem[bus.l_addr[7:2]] = bus.l_wdata;
      exp_cnt = (i < 64) ? 7'(i + 1) : 7'd64;
      @(posedge clk); #1;
      checks++; if (bus.load_count !== exp_cnt) begin errors++; $display("FAIL sat_write%0d got %0d want %0d", i, bus.load_count, exp_cnt); end
      @(negedge clk);
    end
    bus.l_req = 1'b0;
    bus.f_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.f_addr = 32'(4 * i);
      #1;
      checks++; if (bus.f_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt%0d got %b want 1", i, bus.f_gnt); end
      @(posedge clk); #1;
      checks++; if (bus.f_rvalid !== 1'b1 || bus.f_err !== 1'b0 || bus.f_rdata !== exp_mem[i])
        begin errors++; $display("FAIL b2b_resp%0d got v=%b e=%b d=%h want 1 0 %h", i, bus.f_rvalid, bus.f_err, bus.f_rdata, exp_mem[i]); end
      @(negedge clk);
    end
    bus.f_req = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    bus.f_req = 1'b1; bus.f_addr = 32'h0;
    #1;
    checks++; if (bus.f_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %b want 1", bus.f_gnt); end
    #1;
    reset = 1'b1;
    bus.f_req = 1'b0;
    #1;
    checks++; if (bus.f_gnt !== 1'b0 || bus.m_en !== 1'b0) begin errors++; $display("FAIL rmid_gnt_in_reset got gnt=%b en=%b want 0 0", bus.f_gnt, bus.m_en); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.f_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_rvalid_a got %b want 0", bus.f_rvalid); end
    @(negedge clk);
    bus.f_req = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.f_rvalid !== 1'b1) begin errors++; $display("FAIL rmid_rvalid_pre got %b want 1", bus.f_rvalid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.f_rvalid !== 1'b0 || bus.f_rdata !== 32'h0) begin errors++; $display("FAIL rmid_async_clear got v=%b d=%h want 0 0", bus.f_rvalid, bus.f_rdata); end
    @(negedge clk);
    bus.f_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.f_rvalid !== 1'b0 || bus.load_count !== 7'd0)
      begin errors++; $display("FAIL rmid_after_release got v=%b cnt=%0d want 0 0", bus.f_rvalid, bus.load_count); end
    @(negedge clk);
    bus.f_req = 1'b1; bus.l_req = 1'b1; bus.l_addr = 32'h8; bus.l_wdata = 32'h2;
    #1;
    checks++; if (bus.f_gnt !== 1'b1 || bus.l_gnt !== 1'b0) begin errors++; $display("FAIL rmid_first_conflict got f=%b l=%b want 1 0", bus.f_gnt, bus.l_gnt); end
    @(negedge clk);
    idle_inputs();
  endtask

  // Test sequence.
  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h0;
      exp_mem[i] = 32'h0;
    end
    bus.m_rdata = 32'h0;
    test_reset();
    test_load_then_fetch();
    test_round_robin();
    test_illegal();
    test_saturate_and_back_to_back();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
